// File: rtl/decrementer_timer.sv
// Loadable countdown timer with start/busy/done handshake. The decrement is a
// ripple of full-adder cells in subtract mode (count + ~1 + 1).
module decrementer_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             tick,
  input  logic             auto_reload,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [1:0] fulladder(input logic a, input logic b, input logic cin);
    return {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] count_m1_s;
  logic             borrow_s;
  logic [WIDTH-1:0] eff_count_s;
  logic             terminal_s;
  logic             reload_ok_s;

  // Subtract mode: B=1 inverted by M=1, carry-in M=1; carry-out 0 means borrow.
  always_comb begin
    logic       c;
    logic [1:0] fa;
    c = 1'b1;
    count_m1_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      fa = fulladder(count_q[i], ONE[i] ^ 1'b1, c);
      count_m1_s[i] = fa[0];
      c = fa[1];
    end
    borrow_s = ~c;
  end

  assign eff_count_s = load ? load_val : count_q;
  assign terminal_s  = tick && (count_q == ONE);
  assign reload_ok_s = auto_reload && (reload_q != '0);

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && (eff_count_s != '0)) state_d = RUN;
        else                              state_d = IDLE;
      end
      RUN: begin
        if (abort)                          state_d = IDLE;
        else if (terminal_s && !reload_ok_s) state_d = IDLE;
        else                                state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Count, reload register and done pulse.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          count_d  = load_val;
          reload_d = load_val;
        end else begin
          count_d  = count_q;
        end
        if (start && (eff_count_s == '0)) done_d = 1'b1;
        else                              done_d = 1'b0;
      end
      RUN: begin
        if (abort) begin
          count_d = count_q;
        end else if (terminal_s) begin
          done_d  = 1'b1;
          count_d = reload_ok_s ? reload_q : count_m1_s;
        end else if (tick && !borrow_s) begin
          // Borrow guard: a zero count is never decremented into a wrap.
          count_d = count_m1_s;
        end else begin
          count_d = count_q;
        end
      end
      default: begin
        count_d  = '0;
        reload_d = '0;
      end
    endcase
  end

  assign count = count_q;
  assign busy  = (state_q == RUN);
  assign done  = done_q;
  assign zero  = (count_q == '0);

endmodule

// File: tb/tb_decrementer_timer.sv
// Table-driven bench for decrementer_timer with a scoreboard queue of expected
// post-edge outputs, plus hand sequences for async reset and an exhaustive sweep.
module tb_decrementer_timer;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             tick;
  logic             auto_reload;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             zero;

  int checks;
  int errors;

  typedef struct {
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             tick;
    logic             auto_reload;
    logic             abort;
    logic [WIDTH-1:0] exp_count;
    logic             exp_busy;
    logic             exp_done;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             zero;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  decrementer_timer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
    .start(start), .tick(tick), .auto_reload(auto_reload), .abort(abort),
    .count(count), .busy(busy), .done(done), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs, push the expectation, compare after the edge.
  task automatic step(input vec_t v, input string tag);
    exp_t e;
    exp_t got;
    @(negedge clk);
    load        = v.load;
    load_val    = v.load_val;
    start       = v.start;
    tick        = v.tick;
    auto_reload = v.auto_reload;
    abort       = v.abort;
    e.count = v.exp_count;
    e.busy  = v.exp_busy;
    e.done  = v.exp_done;
    e.zero  = (v.exp_count == 4'd0);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: queue empty", tag);
    end else begin
      got = sb_q.pop_front();
      check({tag, " count"}, int'(count), int'(got.count));
      check({tag, " busy"},  int'(busy),  int'(got.busy));
      check({tag, " done"},  int'(done),  int'(got.done));
      check({tag, " zero"},  int'(zero),  int'(got.zero));
    end
  endtask

  function automatic vec_t mk(input logic l, input logic [WIDTH-1:0] lv, input logic s,
                              input logic t, input logic ar, input logic ab,
                              input logic [WIDTH-1:0] ec, input logic eb, input logic ed);
    vec_t v;
    v.load = l; v.load_val = lv; v.start = s; v.tick = t; v.auto_reload = ar; v.abort = ab;
    v.exp_count = ec; v.exp_busy = eb; v.exp_done = ed;
    return v;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    load = 1'b0; load_val = 4'd0; start = 1'b0; tick = 1'b0;
    auto_reload = 1'b0; abort = 1'b0;
    #2;
    check("reset count", int'(count), 0);
    check("reset busy",  int'(busy),  0);
    check("reset done",  int'(done),  0);
    check("reset zero",  int'(zero),  1);
    @(negedge clk);
    rst_n = 1'b1;

    //           ld    lv   st    tk    ar    ab    cnt  busy  done
    // basic countdown from 3
    vecs.push_back(mk(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0));
    // auto-reload from 2
    vecs.push_back(mk(1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1));
    // abort with priority over tick, then resume without load
    vecs.push_back(mk(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0));
    // zero-length countdowns
    vecs.push_back(mk(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1));
    // back-to-back terminal counts with reload of 1
    vecs.push_back(mk(1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    // load/start ignored while running
    vecs.push_back(mk(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

    // async reset mid-RUN, checked before the next clock edge
    #3;
    rst_n = 1'b0;
    #1;
    check("async rst count", int'(count), 0);
    check("async rst busy",  int'(busy),  0);
    check("async rst done",  int'(done),  0);
    @(negedge clk);
    rst_n = 1'b1;

    // async reset while done is high
    step(mk(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0), "pre-rst load");
    step(mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0), "pre-rst start");
    step(mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1), "pre-rst tick");
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst done pulse", int'(done), 0);
    check("async rst zero",       int'(zero), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // exhaustive sweep of every nonzero load value
    for (int v = 1; v < 16; v++) begin
      step(mk(1'b1, 4'(v), 1'b0, 1'b0, 1'b0, 1'b0, 4'(v), 1'b0, 1'b0), $sformatf("sw%0d load", v));
      step(mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'(v), 1'b1, 1'b0), $sformatf("sw%0d start", v));
      for (int k = v - 1; k >= 0; k--) begin
        step(mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'(k), (k != 0), (k == 0)),
             $sformatf("sw%0d cnt%0d", v, k));
      end
      step(mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0), $sformatf("sw%0d nowrap", v));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
